// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle CPU control unit: opcodes, ALU ops, FSM states.
// Optional macro CPU_SINGLE_STEP_EN adds the S_STEP hold state.
package cpu_pkg;

    localparam int unsigned OPW_D  = 4;
    localparam int unsigned ALUW_D = 2;

    localparam logic [OPW_D-1:0] OP_NOP = 4'h0;
    localparam logic [OPW_D-1:0] OP_LDA = 4'h1;
    localparam logic [OPW_D-1:0] OP_STA = 4'h2;
    localparam logic [OPW_D-1:0] OP_ADD = 4'h3;
    localparam logic [OPW_D-1:0] OP_SUB = 4'h4;
    localparam logic [OPW_D-1:0] OP_JMP = 4'h5;
    localparam logic [OPW_D-1:0] OP_JZ  = 4'h6;
    localparam logic [OPW_D-1:0] OP_HLT = 4'hF;

    localparam logic [ALUW_D-1:0] ALU_PASS = 2'd0;
    localparam logic [ALUW_D-1:0] ALU_ADD  = 2'd1;
    localparam logic [ALUW_D-1:0] ALU_SUB  = 2'd2;

    typedef enum logic [2:0] {
        S_START,
        S_FETCH,
        S_DECODE,
        S_MEM_RD,
        S_MEM_WR,
        S_EXEC,
        S_HALT
`ifdef CPU_SINGLE_STEP_EN
        , S_STEP
`endif
    } state_t;

    // Where an instruction goes once it completes.
`ifdef CPU_SINGLE_STEP_EN
    localparam state_t S_CMPL = S_STEP;
`else
    localparam state_t S_CMPL = S_FETCH;
`endif

endpackage

// File: rtl/cpu_ctrl_fsm_op_decode.sv
// Combinational opcode classifier for the CPU control FSM.
module cpu_op_decode
    import cpu_pkg::*;
#(
    parameter int unsigned OPW  = 4,
    parameter int unsigned ALUW = 2
) (
    input  logic [OPW-1:0]  ir_op,
    output logic            is_mem_rd,
    output logic            is_mem_wr,
    output logic            is_jmp,
    output logic            is_jz,
    output logic            is_hlt,
    output logic            is_illegal,
    output logic [ALUW-1:0] alu_op
);

    always_comb begin
        is_mem_rd  = 1'b0;
        is_mem_wr  = 1'b0;
        is_jmp     = 1'b0;
        is_jz      = 1'b0;
        is_hlt     = 1'b0;
        is_illegal = 1'b0;
        alu_op     = ALU_PASS;
        case (ir_op)
            OP_NOP: ;
            OP_LDA: is_mem_rd = 1'b1;
            OP_STA: is_mem_wr = 1'b1;
            OP_ADD: begin
                is_mem_rd = 1'b1;
                alu_op    = ALU_ADD;
            end
            OP_SUB: begin
                is_mem_rd = 1'b1;
                alu_op    = ALU_SUB;
            end
            OP_JMP: is_jmp = 1'b1;
            OP_JZ:  is_jz  = 1'b1;
            OP_HLT: is_hlt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU control FSM: fetch/decode/memory/execute sequencing and retired counter.
// Optional macro CPU_SINGLE_STEP_EN holds each completed instruction until a step pulse.
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int unsigned OPW   = 4,
    parameter int unsigned ALUW  = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPW-1:0]   ir_op,
    input  logic             zero_flag,
    input  logic             mem_ready,
    input  logic             step,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             ir_en,
    output logic             mdr_en,
    output logic             acc_en,
    output logic [ALUW-1:0]  alu_op,
    output logic             illegal,
    output logic             halted,
    output logic [CNT_W-1:0] retired_cnt
);

    state_t          state, nxt;
    logic            cnt_inc;
    logic            is_mem_rd, is_mem_wr, is_jmp, is_jz, is_hlt, is_illegal;
    logic [ALUW-1:0] dec_alu;

    cpu_op_decode #(.OPW(OPW), .ALUW(ALUW)) u_dec (
        .ir_op      (ir_op),
        .is_mem_rd  (is_mem_rd),
        .is_mem_wr  (is_mem_wr),
        .is_jmp     (is_jmp),
        .is_jz      (is_jz),
        .is_hlt     (is_hlt),
        .is_illegal (is_illegal),
        .alu_op     (dec_alu)
    );

`ifndef CPU_SINGLE_STEP_EN
    logic unused_step;
    assign unused_step = step;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_START;
            retired_cnt <= '0;
        end else begin
            state <= nxt;
            if (cnt_inc) retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        nxt      = state;
        cnt_inc  = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        ir_en    = 1'b0;
        mdr_en   = 1'b0;
        acc_en   = 1'b0;
        alu_op   = '0;
        illegal  = 1'b0;
        halted   = 1'b0;
        case (state)
            S_START: begin
`ifdef CPU_SINGLE_STEP_EN
                nxt = S_STEP;
`else
                nxt = S_FETCH;
`endif
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_en  = 1'b1;
                    pc_inc = 1'b1;
                    nxt    = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_mem_rd) begin
                    nxt = S_MEM_RD;
                end else if (is_mem_wr) begin
                    nxt = S_MEM_WR;
                end else if (is_hlt) begin
                    nxt     = S_HALT;
                    cnt_inc = 1'b1;
                end else begin
                    // NOP, JMP, JZ and illegal opcodes all retire straight from decode.
                    pc_load = is_jmp | (is_jz & zero_flag);
                    illegal = is_illegal;
                    nxt     = S_CMPL;
                    cnt_inc = 1'b1;
                end
            end
            S_MEM_RD: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                if (mem_ready) begin
                    mdr_en = 1'b1;
                    nxt    = S_EXEC;
                end
            end
            S_MEM_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_sel = 1'b1;
                if (mem_ready) begin
                    nxt     = S_CMPL;
                    cnt_inc = 1'b1;
                end
            end
            S_EXEC: begin
                acc_en  = 1'b1;
                alu_op  = dec_alu;
                nxt     = S_CMPL;
                cnt_inc = 1'b1;
            end
            S_HALT: halted = 1'b1;
`ifdef CPU_SINGLE_STEP_EN
            S_STEP: if (step) nxt = S_FETCH;
`endif
            default: nxt = S_START;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed self-checking bench for cpu_ctrl_fsm (default build, CNT_W=4 to exercise wrap).
module tb_cpu_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ir_op;
    logic       zero_flag, mem_ready, step;
    logic       mem_req, mem_we, addr_sel, pc_inc, pc_load, ir_en, mdr_en, acc_en;
    logic [1:0] alu_op;
    logic       illegal, halted;
    logic [3:0] retired_cnt;

    int unsigned total = 0;
    int unsigned bad   = 0;

    cpu_ctrl_fsm #(.OPW(4), .ALUW(2), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .ir_op(ir_op), .zero_flag(zero_flag),
        .mem_ready(mem_ready), .step(step), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .pc_inc(pc_inc), .pc_load(pc_load), .ir_en(ir_en),
        .mdr_en(mdr_en), .acc_en(acc_en), .alu_op(alu_op), .illegal(illegal),
        .halted(halted), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    // {mem_req, mem_we, addr_sel, pc_inc, pc_load, ir_en, mdr_en, acc_en, alu_op[1:0], illegal, halted}
    logic [11:0] outs;
    assign outs = {mem_req, mem_we, addr_sel, pc_inc, pc_load, ir_en, mdr_en, acc_en,
                   alu_op, illegal, halted};

    localparam logic [11:0] O_IDLE     = 12'b0000_0000_0000;
    localparam logic [11:0] O_FETCH_RD = 12'b1001_0100_0000;
    localparam logic [11:0] O_FETCH_WT = 12'b1000_0000_0000;
    localparam logic [11:0] O_PCLOAD   = 12'b0000_1000_0000;
    localparam logic [11:0] O_MRD_RD   = 12'b1010_0010_0000;
    localparam logic [11:0] O_MRD_WT   = 12'b1010_0000_0000;
    localparam logic [11:0] O_MWR      = 12'b1110_0000_0000;
    localparam logic [11:0] O_EX_PASS  = 12'b0000_0001_0000;
    localparam logic [11:0] O_EX_ADD   = 12'b0000_0001_0100;
    localparam logic [11:0] O_EX_SUB   = 12'b0000_0001_1000;
    localparam logic [11:0] O_ILL      = 12'b0000_0000_0010;
    localparam logic [11:0] O_HALT     = 12'b0000_0000_0001;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs 2 time units after a rising edge, check 1 later, then advance one cycle.
    task automatic cyc(input string tag, input logic [3:0] op, input logic rdy,
                       input logic zf, input logic [11:0] exp);
        ir_op     = op;
        mem_ready = rdy;
        zero_flag = zf;
        #1;
        chk(tag, {20'd0, outs}, {20'd0, exp});
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; ir_op = 4'h0; zero_flag = 1'b0; mem_ready = 1'b1; step = 1'b0;
        #1;
        chk("rst_outs", {20'd0, outs}, 32'd0);
        chk("rst_cnt", {28'd0, retired_cnt}, 32'd0);
        #11 rst_n = 1'b1;
        #1;
        chk("start_outs", {20'd0, outs}, 32'd0);
        @(posedge clk);
        #2;

        // ADD, zero wait: 4 cycles
        cyc("add_fetch", 4'h3, 1'b1, 1'b0, O_FETCH_RD);
        cyc("add_dec",   4'h3, 1'b1, 1'b0, O_IDLE);
        cyc("add_mrd",   4'h3, 1'b1, 1'b0, O_MRD_RD);
        cyc("add_exec",  4'h3, 1'b1, 1'b0, O_EX_ADD);
        chk("add_cnt", {28'd0, retired_cnt}, 32'd1);

        // STA, 3 wait cycles: request held 4 cycles
        cyc("sta_fetch", 4'h2, 1'b1, 1'b0, O_FETCH_RD);
        cyc("sta_dec",   4'h2, 1'b0, 1'b0, O_IDLE);
        cyc("sta_w1",    4'h2, 1'b0, 1'b0, O_MWR);
        cyc("sta_w2",    4'h2, 1'b0, 1'b0, O_MWR);
        cyc("sta_w3",    4'h2, 1'b0, 1'b0, O_MWR);
        cyc("sta_done",  4'h2, 1'b1, 1'b0, O_MWR);
        chk("sta_cnt", {28'd0, retired_cnt}, 32'd2);

        // JZ taken / not taken
        cyc("jz1_fetch", 4'h6, 1'b1, 1'b1, O_FETCH_RD);
        cyc("jz1_dec",   4'h6, 1'b1, 1'b1, O_PCLOAD);
        cyc("jz0_fetch", 4'h6, 1'b1, 1'b0, O_FETCH_RD);
        cyc("jz0_dec",   4'h6, 1'b1, 1'b0, O_IDLE);
        chk("jz_cnt", {28'd0, retired_cnt}, 32'd4);

        // JMP always loads
        cyc("jmp_fetch", 4'h5, 1'b1, 1'b0, O_FETCH_RD);
        cyc("jmp_dec",   4'h5, 1'b1, 1'b0, O_PCLOAD);

        // Illegal opcode: single-cycle pulse, then a waiting fetch
        cyc("ill_fetch", 4'h9, 1'b1, 1'b0, O_FETCH_RD);
        cyc("ill_dec",   4'h9, 1'b1, 1'b0, O_ILL);
        cyc("ill_after", 4'h9, 1'b0, 1'b0, O_FETCH_WT);
        chk("ill_cnt", {28'd0, retired_cnt}, 32'd6);

        // LDA with one read wait, SUB zero wait
        cyc("lda_fetch", 4'h1, 1'b1, 1'b0, O_FETCH_RD);
        cyc("lda_dec",   4'h1, 1'b1, 1'b0, O_IDLE);
        cyc("lda_wait",  4'h1, 1'b0, 1'b0, O_MRD_WT);
        cyc("lda_mrd",   4'h1, 1'b1, 1'b0, O_MRD_RD);
        cyc("lda_exec",  4'h1, 1'b1, 1'b0, O_EX_PASS);
        cyc("sub_fetch", 4'h4, 1'b1, 1'b0, O_FETCH_RD);
        cyc("sub_dec",   4'h4, 1'b1, 1'b0, O_IDLE);
        cyc("sub_mrd",   4'h4, 1'b1, 1'b0, O_MRD_RD);
        cyc("sub_exec",  4'h4, 1'b1, 1'b0, O_EX_SUB);
        chk("sub_cnt", {28'd0, retired_cnt}, 32'd8);

        // Reset in the middle of a read access
        cyc("rr_fetch", 4'h1, 1'b1, 1'b0, O_FETCH_RD);
        cyc("rr_dec",   4'h1, 1'b1, 1'b0, O_IDLE);
        mem_ready = 1'b0;
        #1;
        chk("rr_mrd", {20'd0, outs}, {20'd0, O_MRD_WT});
        rst_n = 1'b0;
        #1;
        chk("rr_outs", {20'd0, outs}, 32'd0);
        chk("rr_cnt", {28'd0, retired_cnt}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("rr_start", {20'd0, outs}, 32'd0);
        @(posedge clk);
        #2;
        cyc("rr_fetch2", 4'h0, 1'b0, 1'b0, O_FETCH_WT);

        // 17 NOPs on a 4-bit counter: wraps back to 1
        for (int i = 0; i < 17; i++) begin
            cyc("nop_fetch", 4'h0, 1'b1, 1'b0, O_FETCH_RD);
            cyc("nop_dec",   4'h0, 1'b1, 1'b0, O_IDLE);
        end
        chk("nop_wrap", {28'd0, retired_cnt}, 32'd1);

        // HLT: sticks, ignores mem_ready, counts once
        cyc("hlt_fetch", 4'hF, 1'b1, 1'b0, O_FETCH_RD);
        cyc("hlt_dec",   4'hF, 1'b1, 1'b0, O_IDLE);
        for (int i = 0; i < 4; i++) begin
            cyc("halt_hold", 4'h3, logic'(i[0]), 1'b0, O_HALT);
        end
        chk("halt_cnt", {28'd0, retired_cnt}, 32'd2);

        rst_n = 1'b0;
        #1;
        chk("final_rst", {20'd0, outs}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
